instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the IF/ID pipeline register: owns the PC, issues instruction-memory
//  reads over a req/ready handshake, presents instr/pc/valid to IF/ID. Handles hazard-unit
//  stall and branch/jump redirect from EX. One outstanding fetch max; one instr/cycle with zero-wait memory.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  PC_STEP   4              sequential PC increment (bytes)
// PORTS
//  clk               in   1   rising-edge clock
//  rst_n             in   1   asynchronous active-low reset
//  stall_i           in   1   hazard unit: hold fetch outputs this cycle
//  redirect_valid_i  in   1   taken branch/jump: restart fetch at redirect_pc_i
//  redirect_pc_i     in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req_o        out  1   fetch request valid
//  imem_addr_o       out  32  fetch address (= internal pc_r)
//  imem_ready_i      in   1   memory accepts req AND returns imem_rdata_i this cycle
//  imem_rdata_i      in   32  fetched instruction, valid only when req & ready
//  instr_o           out  32  instruction to IF/ID (registered)
//  instr_valid_o     out  1   instr_o holds a live instruction (registered)
//  pc_o              out  32  PC of instr_o (registered)
// BEHAVIOUR
//  Reset (async, any state): pc_r=RESET_PC, state=IDLE, imem_req_o=0, instr_o=0, instr_valid_o=0,
//   pc_o=0, hold buffer empty, kill flag 0. Mid-operation reset aborts pending fetch; no response used.
//  States: IDLE, REQ, HOLD, DRAIN. imem_req_o=1 only in REQ and DRAIN.
//  Handshake: while req=1 and ready=0, imem_addr_o must stay stable (memory may sample late).
//  IDLE: first cycle after reset release; -> REQ.
//  REQ, ready=1, no stall/redirect: instr_o<=rdata, instr_valid_o<=1, pc_o<=pc_r, pc_r<=pc_r+PC_STEP;
//   stay REQ (back-to-back). Latency addr->instr_o = 1 cycle after ready.
//  REQ, ready=0, no stall: instr_valid_o<=0 (bubble); instr_o/pc_o keep value.
//  REQ, ready=1, stall: outputs held; rdata+pc_r into hold buffer; pc_r advances; -> HOLD.
//  REQ, ready=0, stall: outputs held; stay REQ.
//  HOLD: imem_req_o=0; outputs held while stall_i=1. stall_i=0: buffer -> instr_o/pc_o,
//   instr_valid_o<=1, buffer cleared, -> REQ.
//  Stall_i=1 in any state: instr_o, pc_o, instr_valid_o unchanged that cycle.
//  Redirect (priority over stall and ready, any state except IDLE):
//   pc_r<=redirect_pc_i&~3, instr_valid_o<=0, instr_o<=0, hold buffer cleared.
//   - REQ with ready=0 (fetch pending): -> DRAIN, address held; pc_r already updated internally
//     (imem_addr_o driven from latched pending address in DRAIN).
//   - REQ with ready=1 or HOLD: rdata discarded, -> REQ at new PC next cycle.
//   - DRAIN: new target overwrites pc_r; stay DRAIN.
//  DRAIN: wait ready=1, discard rdata, -> REQ at pc_r. instr_valid_o=0 throughout.
//  PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
// STRUCTURE
//  Package fetch_pkg: FETCH_STATE_T enum {IDLE,REQ,HOLD,DRAIN}, PC_W=32, INSTR_W=32,
//   default RESET_PC/PC_STEP constants.
//  One sub-module: fetch_hold_buf (1-entry instr+pc buffer, load/clear/valid, async rst_n).
//  Top: FSM, pc_r, pending-addr latch, output registers.
// TESTING
//  1 Zero-wait mem (ready=1 always), RESET_PC=0: after reset, pc_o=0,4,8,... on successive cycles,
//    instr_valid_o=1 from 2nd cycle after release; instr_o matches memory model.
//  2 ready=0 for 3 cycles at addr 0x10: imem_addr_o stable 0x10, instr_valid_o=0 for those
//    cycles, then instr @0x10 appears one cycle after ready.
//  3 stall_i high 4 cycles while ready=1: instr_o/pc_o frozen, one fetch buffered (HOLD, req=0);
//    on release, buffered pc=next sequential appears, no instr lost or duplicated.
//  4 redirect to 0x200 with fetch pending at 0x40 (ready=0): DRAIN holds addr 0x40, response
//    discarded, next req addr=0x200, first valid pc_o=0x200; redirect+stall same cycle -> redirect wins.
//  5 redirect_pc_i=0x103 -> fetch at 0x100; redirect to 0xFFFF_FFFC -> next fetch 0x0000_0000.
//  6 rst_n asserted mid-DRAIN: outputs to reset values immediately (async), after release fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEF_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} FETCH_STATE_T;

  // Instructions are word aligned; the low two address bits are never fetched.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking a fetched instr+pc while the decode stage is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clr,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads, feeds the IF/ID register,
// absorbs hazard stalls and EX redirects (one outstanding fetch at most).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [PC_W-1:0]    pc_o
);
  FETCH_STATE_T       r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [PC_W-1:0]    r_pend_addr;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [PC_W-1:0]    r_pc_o, w_pc_o_nxt;
  logic               r_vld, w_vld_nxt;
  logic               w_pend_ld, w_buf_ld, w_buf_clr, w_buf_vld;
  logic [INSTR_W-1:0] w_buf_instr;
  logic [PC_W-1:0]    w_buf_pc;
  logic               w_redir;
  logic [PC_W-1:0]    w_redir_pc;

  // IDLE is the post-reset settling cycle; a redirect there is not honoured.
  assign w_redir    = redirect_valid_i && (r_state != IDLE);
  assign w_redir_pc = align_pc(redirect_pc_i);

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_ld),
    .i_clr   (w_buf_clr),
    .i_instr (imem_rdata_i),
    .i_pc    (r_pc),
    .o_valid (w_buf_vld),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  // Next-state, next-PC and IF/ID output update; redirect > stall > ready.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc_o_nxt  = r_pc_o;
    w_vld_nxt   = r_vld;
    w_pend_ld   = 1'b0;
    w_buf_ld    = 1'b0;
    w_buf_clr   = 1'b0;
    if (w_redir) begin
      w_pc_nxt    = w_redir_pc;
      w_instr_nxt = '0;
      w_vld_nxt   = 1'b0;
      w_buf_clr   = 1'b1;
      case (r_state)
        // A pending read must still complete at its original address.
        REQ:     if (!imem_ready_i) begin
                   w_state_nxt = DRAIN;
                   w_pend_ld   = 1'b1;
                 end
        HOLD:    w_state_nxt = REQ;
        DRAIN:   if (imem_ready_i) w_state_nxt = REQ;
        default: ;
      endcase
    end else begin
      case (r_state)
        IDLE: w_state_nxt = REQ;
        REQ: begin
          if (stall_i) begin
            if (imem_ready_i) begin
              w_buf_ld    = 1'b1;
              w_pc_nxt    = r_pc + PC_STEP;
              w_state_nxt = HOLD;
            end
          end else if (imem_ready_i) begin
            w_instr_nxt = imem_rdata_i;
            w_pc_o_nxt  = r_pc;
            w_vld_nxt   = 1'b1;
            w_pc_nxt    = r_pc + PC_STEP;
          end else begin
            w_vld_nxt   = 1'b0;
          end
        end
        HOLD: if (!stall_i && w_buf_vld) begin
          w_instr_nxt = w_buf_instr;
          w_pc_o_nxt  = w_buf_pc;
          w_vld_nxt   = 1'b1;
          w_buf_clr   = 1'b1;
          w_state_nxt = REQ;
        end
        DRAIN: if (imem_ready_i) w_state_nxt = REQ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, PC, pending-address latch and IF/ID output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_pend_addr <= '0;
      r_instr     <= '0;
      r_pc_o      <= '0;
      r_vld       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc_o  <= w_pc_o_nxt;
      r_vld   <= w_vld_nxt;
      if (w_pend_ld) r_pend_addr <= r_pc;
    end
  end

  // In DRAIN the PC already holds the redirect target, so the bus keeps the old address.
  assign imem_req_o    = (r_state == REQ) || (r_state == DRAIN);
  assign imem_addr_o   = (r_state == DRAIN) ? r_pend_addr : r_pc;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_o;
  assign instr_valid_o = r_vld;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected pcs, a
// negedge monitor pops and compares each newly presented instruction.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];
  logic stall_q;

  instr_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_ready_i     (imem_ready_i),
    .imem_rdata_i     (imem_rdata_i),
    .instr_o          (instr_o),
    .instr_valid_o    (instr_valid_o),
    .pc_o             (pc_o)
  );

  always #5 clk = ~clk;

  // Memory model: each word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  assign imem_rdata_i = mem_word(imem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Stall as seen by the DUT at the last rising edge: a held output is not a new instr.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= 1'b0;
    else        stall_q <= stall_i;

  // Monitor: every freshly loaded valid instruction must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && instr_valid_o && !stall_q) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL mon_unexpected: got pc %h instr %h expected none", pc_o, instr_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("mon_pc", pc_o, e);
        chk("mon_instr", instr_o, mem_word(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_pc_i = '0; imem_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);

    // 1: zero-wait back-to-back fetches from RESET_PC
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);  exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // 2: memory wait at 0x10, address must stay put
    imem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_addr", imem_addr_o, 32'h10);
      chk("wait_req", {31'd0, imem_req_o}, 32'd1);
      if (i > 0) chk("wait_bubble", {31'd0, instr_valid_o}, 32'd0);
      tick();
    end
    imem_ready_i = 1'b1;
    tick();

    // 3: stall 4 cycles with ready high; one fetch parked in the hold buffer
    exp_q.push_back(32'h14);
    stall_i = 1'b1;
    tick();
    @(negedge clk);
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    chk("hold_pc_o", pc_o, 32'h10);
    chk("hold_instr", instr_o, mem_word(32'h10));
    repeat (3) tick();
    stall_i = 1'b0;
    tick();

    // 4: run to 0x40, make it pending, then redirect+stall to 0x200
    for (int a = 32'h18; a < 32'h40; a += 4) exp_q.push_back(a);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_addr_o == 32'h40) break;
    end
    chk("reach_40", imem_addr_o, 32'h40);
    imem_ready_i = 1'b0;
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h200; stall_i = 1'b1;
    tick();
    redirect_valid_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    chk("drain_req", {31'd0, imem_req_o}, 32'd1);
    chk("drain_addr", imem_addr_o, 32'h40);
    chk("drain_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("drain_instr", instr_o, 32'd0);
    tick();
    @(negedge clk);
    chk("drain_addr2", imem_addr_o, 32'h40);
    tick();
    imem_ready_i = 1'b1;
    tick();
    @(negedge clk);
    chk("redir_addr", imem_addr_o, 32'h200);
    chk("redir_valid", {31'd0, instr_valid_o}, 32'd0);
    exp_q.push_back(32'h200);
    tick();

    // 5: misaligned redirect target and PC wrap
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h103;
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("align_addr", imem_addr_o, 32'h100);
    chk("align_valid", {31'd0, instr_valid_o}, 32'd0);
    exp_q.push_back(32'h100);
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("top_addr", imem_addr_o, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    @(negedge clk);
    chk("wrap_addr", imem_addr_o, 32'h0);
    repeat (2) tick();

    // 6: async reset while draining
    imem_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h300;
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("d2_addr", imem_addr_o, 32'h8);
    chk("d2_pc_o", pc_o, 32'h4);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("arst_pc_o", pc_o, 32'd0);
    chk("arst_addr", imem_addr_o, 32'd0);
    chk("arst_q_empty", exp_q.size(), 32'd0);
    imem_ready_i = 1'b1;
    repeat (2) tick();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_addr", imem_addr_o, 32'h0);
    chk("post_rst_req", {31'd0, imem_req_o}, 32'd1);
    repeat (2) tick();
    imem_ready_i = 1'b0;
    repeat (3) tick();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
